// File: rtl/seg_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment scan driver.
// Segment patterns are in {a..g} order, segment a in bit 6.
package seg_pkg;

  localparam int MAX_DIG = 8;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;

  // Active-low one-hot enable: bit idx low when idx < width, all other bits high.
  function automatic logic [MAX_DIG-1:0] dig_enb_n(input int idx, input int width);
    logic [MAX_DIG-1:0] r;
    for (int i = 0; i < MAX_DIG; i++) begin
      r[i] = !((i == idx) && (i < width));
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Slot counter and digit index for the scan driver; flags slot start, frame start
// and the DRIVE phase. With SEG_SCAN_DIM_EN defined it also exports sc[3:0].
module seg_slot_timer #(
  parameter int NUM_DIG = 6,
  parameter int DIV     = 50000,
  parameter int BLANK   = 500,
  parameter int SCW     = $clog2(DIV),
  parameter int DW      = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
`ifdef SEG_SCAN_DIM_EN
  output logic [3:0]    sc_lo,
`endif
  output logic          slot_start,
  output logic          frame_start,
  output logic          drive,
  output logic [DW-1:0] di
);

  logic [SCW-1:0] sc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sc <= '0;
      di <= '0;
    end else if (sc == SCW'(DIV - 1)) begin
      sc <= '0;
      di <= (di == DW'(NUM_DIG - 1)) ? '0 : di + 1'b1;
    end else begin
      sc <= sc + 1'b1;
    end
  end

  assign slot_start  = (sc == '0);
  assign frame_start = slot_start && (di == '0);
  assign drive       = (sc >= SCW'(BLANK));

`ifdef SEG_SCAN_DIM_EN
  // Short slot counters are zero-extended so the dimming compare is always 4 bits.
  if (SCW >= 4) begin : g_sc_lo_wide
    assign sc_lo = sc[3:0];
  end else begin : g_sc_lo_narrow
    assign sc_lo = {{(4 - SCW){1'b0}}, sc};
  end
`endif

endmodule

// File: rtl/seg_scan_mux.sv
// N-digit multiplexed seven-segment scan driver with per-slot blanking, digit mask,
// slot-start input capture and frame pulse. Optional SEG_SCAN_DIM_EN adds i_bright.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int NUM_DIG = 6,
  parameter int DIV     = 50000,
  parameter int BLANK   = 500
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7*NUM_DIG-1:0] i_digit_seg,
  input  logic [NUM_DIG-1:0]   i_dp,
  input  logic [NUM_DIG-1:0]   i_dig_on,
`ifdef SEG_SCAN_DIM_EN
  input  logic [3:0]           i_bright,
`endif
  output logic [6:0]           o_seg,
  output logic                 o_seg_dp,
  output logic [NUM_DIG-1:0]   o_seg_enb,
  output logic                 o_frame
);

  localparam int SCW = $clog2(DIV);
  localparam int DW  = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;

  logic          slot_start;
  logic          frame_start;
  logic          drive;
  logic [DW-1:0] di;
  logic          gate_on;
  logic          show;
  logic [6:0]    sel_seg;
  logic          sel_dp;
  logic          sel_on;
  logic [6:0]    cur_seg;
  logic          cur_dp;
  logic          cur_on;

`ifdef SEG_SCAN_DIM_EN
  logic [3:0] sc_lo;
`endif

  seg_slot_timer #(
    .NUM_DIG(NUM_DIG),
    .DIV    (DIV),
    .BLANK  (BLANK),
    .SCW    (SCW),
    .DW     (DW)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef SEG_SCAN_DIM_EN
    .sc_lo      (sc_lo),
`endif
    .slot_start (slot_start),
    .frame_start(frame_start),
    .drive      (drive),
    .di         (di)
  );

  always_comb begin
    sel_seg = SEG_BLANK;
    sel_dp  = 1'b0;
    sel_on  = 1'b0;
    for (int k = 0; k < NUM_DIG; k++) begin
      if (di == DW'(k)) begin
        sel_seg = i_digit_seg[7*k +: 7];
        sel_dp  = i_dp[k];
        sel_on  = i_dig_on[k];
      end
    end
  end

`ifdef SEG_SCAN_DIM_EN
  // 4'hF is full brightness; otherwise lit for i_bright of every 16 cycles.
  assign gate_on = (i_bright == 4'hF) || (sc_lo < i_bright);
`else
  assign gate_on = 1'b1;
`endif

  assign show = drive && cur_on && gate_on;

  // Capture lands on the slot's first edge, which is always in BLANK, so the
  // freshly captured digit is never shown with the previous slot's enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_seg   <= SEG_BLANK;
      cur_dp    <= 1'b0;
      cur_on    <= 1'b0;
      o_seg     <= SEG_BLANK;
      o_seg_dp  <= 1'b0;
      o_seg_enb <= '1;
      o_frame   <= 1'b0;
    end else begin
      if (slot_start) begin
        cur_seg <= sel_seg;
        cur_dp  <= sel_dp;
        cur_on  <= sel_on;
      end
      o_frame <= frame_start;
      if (show) begin
        o_seg     <= cur_seg;
        o_seg_dp  <= cur_dp;
        o_seg_enb <= NUM_DIG'(dig_enb_n(int'(di), NUM_DIG));
      end else begin
        o_seg     <= SEG_BLANK;
        o_seg_dp  <= 1'b0;
        o_seg_enb <= '1;
      end
    end
  end

endmodule
